// File: rtl/instr_assemble.sv
// Encodes R/D-format field sets into instruction words, buffers them in a small FIFO
// and drains them into instruction memory at consecutive addresses from base_addr.
`ifndef INSTR_LEN
`define INSTR_LEN 32
`endif

module instr_assemble #(
   parameter int DEPTH = 4,
   parameter int AW    = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [AW-1:0]          base_addr,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic                   in_fmt,
   input  logic [10:0]            in_opcode,
   input  logic [4:0]             in_rm,
   input  logic [4:0]             in_rn,
   input  logic [4:0]             in_rd,
   input  logic [8:0]             in_address,
   input  logic                   in_last,
   input  logic                   mem_stall,
   output logic                   imem_we,
   output logic [AW-1:0]          imem_addr,
   output logic [`INSTR_LEN-1:0]  imem_wdata,
   output logic                   busy,
   output logic                   done,
   output logic                   overflow,
   output logic [AW:0]            word_count
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PW:0]   OCC_ONE   = (PW+1)'(1);
   localparam logic [PW:0]   OCC_FULL  = (PW+1)'(DEPTH);
   localparam logic [PW-1:0] IDX_ONE   = PW'(1);
   localparam logic [AW-1:0] PTR_ONE   = AW'(1);
   localparam logic [AW:0]   COUNT_ONE = (AW+1)'(1);

   typedef enum logic [2:0] {IDLE, RUN, FLUSH, DONE, ERR} state_t;

   state_t                  state, state_nxt;
   logic [`INSTR_LEN-1:0]   fifo_mem [DEPTH];
   logic [PW-1:0]           rd_idx, wr_idx;
   logic [PW:0]             occ;
   logic [AW-1:0]           wptr;
   logic [AW:0]             wcount;
   logic                    ovf;
   logic                    fifo_empty, fifo_full, ready_int, push, pop, active, at_top, restart;
   logic [`INSTR_LEN-1:0]   enc_word;

   function automatic logic [`INSTR_LEN-1:0] encode(
      input logic        fmt,
      input logic [10:0] opcode,
      input logic [4:0]  rm,
      input logic [4:0]  rn,
      input logic [4:0]  rd,
      input logic [8:0]  address
   );
      logic [`INSTR_LEN-1:0] w;
      w        = '0;
      w[31:21] = opcode;
      w[9:5]   = rn;
      w[4:0]   = rd;
      if (fmt) w[20:12] = address;
      else     w[20:16] = rm;
      return w;
   endfunction

   always_comb begin
      enc_word   = encode(in_fmt, in_opcode, in_rm, in_rn, in_rd, in_address);
      fifo_empty = (occ == '0);
      fifo_full  = (occ == OCC_FULL);
      active     = (state == RUN) || (state == FLUSH);
      ready_int  = (state == RUN) && !fifo_full;
      push       = in_valid && ready_int;
      pop        = active && !fifo_empty && !mem_stall;
      at_top     = &wptr;
      restart    = start && !active;
   end

   // Reset forces every output low, including ones derived from stale state.
   always_comb begin
      in_ready   = !rst && ready_int;
      imem_we    = !rst && pop;
      imem_addr  = rst ? '0 : wptr;
      imem_wdata = rst ? '0 : fifo_mem[rd_idx];
      busy       = !rst && active;
      done       = !rst && (state == DONE);
      overflow   = !rst && ovf;
      word_count = rst ? '0 : wcount;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, DONE, ERR: if (start) state_nxt = RUN;
         RUN:             if (push && in_last) state_nxt = FLUSH;
         FLUSH:           if (fifo_empty) state_nxt = DONE;
         default:         state_nxt = IDLE;
      endcase
      if (pop && at_top) state_nxt = ERR;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         rd_idx <= '0;
         wr_idx <= '0;
         occ    <= '0;
         wptr   <= '0;
         wcount <= '0;
         ovf    <= 1'b0;
      end else begin
         state <= state_nxt;
         if (restart) begin
            rd_idx <= '0;
            wr_idx <= '0;
            occ    <= '0;
            wptr   <= base_addr;
            wcount <= '0;
            ovf    <= 1'b0;
         end else if (pop && at_top) begin
            // Last address just written: keep the pointer, drop everything still queued.
            rd_idx <= '0;
            wr_idx <= '0;
            occ    <= '0;
            wcount <= wcount + COUNT_ONE;
            ovf    <= 1'b1;
         end else begin
            if (push) wr_idx <= wr_idx + IDX_ONE;
            if (pop) begin
               rd_idx <= rd_idx + IDX_ONE;
               wptr   <= wptr + PTR_ONE;
               wcount <= wcount + COUNT_ONE;
            end
            case ({push, pop})
               2'b10:   occ <= occ + OCC_ONE;
               2'b01:   occ <= occ - OCC_ONE;
               default: occ <= occ;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_idx] <= enc_word;
   end

endmodule

// File: tb/tb_instr_assemble.sv
// Randomized and directed bench for instr_assemble against a queue-based session model.
module tb_instr_assemble;

   localparam int DEPTH = 4;
   localparam int AW    = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [AW-1:0] base_addr = '0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic          in_fmt = 1'b0;
   logic [10:0]   in_opcode = '0;
   logic [4:0]    in_rm = '0, in_rn = '0, in_rd = '0;
   logic [8:0]    in_address = '0;
   logic          in_last = 1'b0;
   logic          mem_stall = 1'b0;
   logic          imem_we;
   logic [AW-1:0] imem_addr;
   logic [31:0]   imem_wdata;
   logic          busy, done, overflow;
   logic [AW:0]   word_count;

   instr_assemble #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
      .in_valid(in_valid), .in_ready(in_ready), .in_fmt(in_fmt),
      .in_opcode(in_opcode), .in_rm(in_rm), .in_rn(in_rn), .in_rd(in_rd),
      .in_address(in_address), .in_last(in_last), .mem_stall(mem_stall),
      .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
      .busy(busy), .done(done), .overflow(overflow), .word_count(word_count)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int failed = 0;
   logic rand_stall = 1'b0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] enc(input bit fmt, input int op, input int rm, input int rn,
                                       input int rd, input int addr);
      if (fmt) return 32'((op % 2048) * (1 << 21) + (addr % 512) * (1 << 12) + (rn % 32) * 32 + (rd % 32));
      else     return 32'((op % 2048) * (1 << 21) + (rm % 32) * (1 << 16) + (rn % 32) * 32 + (rd % 32));
   endfunction

   // Session model: mode 0=idle 1=loading 2=finishing 3=complete 4=error.
   int           m_mode = 0;
   logic [31:0]  m_q[$];
   int           m_ptr = 0;
   int           m_count = 0;
   bit           m_ovf = 0;

   always @(posedge clk) begin
      bit loading, writing, accept, was_empty;
      if (rst) begin
         m_mode = 0; m_q.delete(); m_ptr = 0; m_count = 0; m_ovf = 0;
      end else begin
         loading   = (m_mode == 1) || (m_mode == 2);
         was_empty = (m_q.size() == 0);
         accept    = (m_mode == 1) && (m_q.size() < DEPTH) && in_valid;
         writing   = loading && !was_empty && !mem_stall;
         if (start && !loading) begin
            m_mode = 1; m_q.delete(); m_ptr = int'(base_addr); m_count = 0; m_ovf = 0;
         end else if (writing && m_ptr == (1 << AW) - 1) begin
            m_count++; m_ovf = 1; m_mode = 4; m_q.delete();
         end else begin
            if (writing) begin
               void'(m_q.pop_front()); m_ptr++; m_count++;
            end
            if (accept) m_q.push_back(enc(in_fmt, in_opcode, in_rm, in_rn, in_rd, in_address));
            if (accept && in_last) m_mode = 2;
            else if (m_mode == 2 && was_empty) m_mode = 3;
         end
      end
   end

   int          log_addr[$];
   logic [31:0] log_data[$];

   always @(negedge clk) begin
      bit exp_we;
      if (rst) begin
         chk("rst_ready", in_ready, 0); chk("rst_we", imem_we, 0);
         chk("rst_busy", busy, 0);      chk("rst_done", done, 0);
         chk("rst_ovf", overflow, 0);   chk("rst_addr", imem_addr, 0);
         chk("rst_wdata", imem_wdata, 0); chk("rst_count", word_count, 0);
      end else begin
         exp_we = (m_mode == 1 || m_mode == 2) && m_q.size() > 0 && !mem_stall;
         chk("in_ready", in_ready, (m_mode == 1) && (m_q.size() < DEPTH));
         chk("imem_we", imem_we, exp_we);
         if (exp_we) begin
            chk("imem_addr", imem_addr, m_ptr);
            chk("imem_wdata", imem_wdata, m_q[0]);
         end
         chk("busy", busy, (m_mode == 1 || m_mode == 2));
         chk("done", done, m_mode == 3);
         chk("overflow", overflow, m_ovf);
         chk("word_count", word_count, m_count);
      end
      if (imem_we) begin
         log_addr.push_back(int'(imem_addr));
         log_data.push_back(imem_data_copy(imem_wdata));
      end
   end

   function automatic logic [31:0] imem_data_copy(input logic [31:0] d);
      return d;
   endfunction

   always @(posedge clk) begin
      if (rand_stall) begin
         #1;
         mem_stall = 1'($urandom % 2);
      end
   end

   task automatic cycles(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic pulse_start(input int base);
      start = 1'b1; base_addr = AW'(base);
      cycles(1);
      start = 1'b0;
   endtask

   task automatic send(input bit fmt, input int op, input int rm, input int rn, input int rd,
                       input int addr, input bit last, input int maxc, output bit ok);
      bit acc;
      in_valid = 1'b1; in_fmt = fmt; in_opcode = 11'(op); in_rm = 5'(rm); in_rn = 5'(rn);
      in_rd = 5'(rd); in_address = 9'(addr); in_last = last;
      ok = 0;
      for (int i = 0; i < maxc && !ok; i++) begin
         @(negedge clk); acc = in_ready;
         @(posedge clk); #1; ok = acc;
      end
      in_valid = 1'b0; in_last = 1'b0;
   endtask

   task automatic send_rand(input bit last, input int maxc, output bit ok, output logic [31:0] w);
      bit f; int op, rm, rn, rd, ad;
      f = 1'($urandom % 2); op = int'($urandom % 2048); rm = int'($urandom % 32);
      rn = int'($urandom % 32); rd = int'($urandom % 32); ad = int'($urandom % 512);
      w = enc(f, op, rm, rn, rd, ad);
      send(f, op, rm, rn, rd, ad, last, maxc, ok);
   endtask

   task automatic wait_end(input string nm);
      bit hit = 0;
      for (int i = 0; i < 500 && !hit; i++) begin
         @(negedge clk); hit = done || overflow;
      end
      if (!hit) begin
         tests++; failed++;
         $display("FAIL %s_timeout: got no done/overflow, required one within 500 cycles", nm);
      end
      @(posedge clk); #1;
   endtask

   initial begin
      bit ok;
      int n0, nacc;
      logic [31:0] w, words[6];

      cycles(3);
      rst = 1'b0;
      cycles(1);

      // Basic R-format
      pulse_start('h10);
      send(0, 'h458, 2, 1, 3, 0, 1, 5, ok);
      chk("r_accept", ok, 1);
      @(negedge clk);
      chk("r_we_lat1", imem_we, 1); chk("r_addr_lat1", imem_addr, 'h10);
      chk("r_wdata_lat1", imem_wdata, 32'h8B020023);
      wait_end("r");
      @(negedge clk);
      chk("r_done", done, 1); chk("r_count", word_count, 1);
      chk("r_log_data", log_data[$], 32'h8B020023);

      // Basic D-format
      @(posedge clk); #1;
      pulse_start('h20);
      send(1, 'h7C2, 0, 2, 5, 8, 1, 5, ok);
      wait_end("d");
      chk("d_log_addr", log_addr[$], 'h20);
      chk("d_log_data", log_data[$], 32'hF8408045);
      chk("d_bits11_10", log_data[$] & 32'h0000_0C00, 0);

      // Backpressure
      mem_stall = 1'b1;
      pulse_start('h40);
      n0 = log_addr.size(); nacc = 0;
      for (int i = 0; i < 4; i++) begin
         send(i % 2 == 1, 100 + i, i, i + 1, i + 2, 16 * i, 0, 3, ok);
         words[i] = enc(i % 2 == 1, 100 + i, i, i + 1, i + 2, 16 * i);
         nacc += int'(ok);
      end
      send(0, 200, 7, 8, 9, 0, 0, 5, ok);
      chk("bp_hold", ok, 0);
      chk("bp_acc", nacc, 4);
      chk("bp_nowrite", log_addr.size() - n0, 0);
      mem_stall = 1'b0;
      send(0, 200, 7, 8, 9, 0, 0, 10, ok); words[4] = enc(0, 200, 7, 8, 9, 0);
      send(1, 201, 0, 10, 11, 300, 1, 10, ok); words[5] = enc(1, 201, 0, 10, 11, 300);
      wait_end("bp");
      chk("bp_total", log_addr.size() - n0, 6);
      for (int i = 0; i < 6; i++) begin
         if (n0 + i < log_addr.size()) begin
            chk("bp_addr", log_addr[n0 + i], 'h40 + i);
            chk("bp_data", log_data[n0 + i], words[i]);
         end
      end

      // Overflow at the top of memory
      pulse_start('hFE);
      n0 = log_addr.size();
      send_rand(0, 5, ok, w);
      send_rand(0, 5, ok, w);
      send_rand(1, 5, ok, w);
      wait_end("ovf");
      cycles(3);
      @(negedge clk);
      chk("ovf_writes", log_addr.size() - n0, 2);
      chk("ovf_addr0", log_addr[n0], 'hFE);
      chk("ovf_addr1", log_addr[n0 + 1], 'hFF);
      chk("ovf_flag", overflow, 1); chk("ovf_ready", in_ready, 0);
      chk("ovf_busy", busy, 0);
      @(posedge clk); #1;

      // Reset mid-session, then clean restart
      mem_stall = 1'b1;
      pulse_start('h80);
      send_rand(0, 5, ok, w);
      send_rand(0, 5, ok, w);
      n0 = log_addr.size();
      rst = 1'b1; start = 1'b1; base_addr = 'h55; in_valid = 1'b1;
      cycles(1);
      rst = 1'b0; start = 1'b0; in_valid = 1'b0; mem_stall = 1'b0;
      cycles(5);
      chk("rst_nowrite", log_addr.size() - n0, 0);
      pulse_start('h00);
      send_rand(1, 5, ok, w);
      wait_end("restart");
      chk("restart_addr", log_addr[$], 0);
      chk("restart_data", log_data[$], w);
      chk("restart_count", word_count, 1);

      // Start during a session is ignored
      mem_stall = 1'b1;
      pulse_start('h30);
      n0 = log_addr.size();
      send_rand(0, 5, ok, w);
      send_rand(0, 5, ok, w);
      pulse_start('h99);
      mem_stall = 1'b0;
      send_rand(1, 10, ok, w);
      wait_end("ign");
      chk("ign_writes", log_addr.size() - n0, 3);
      chk("ign_addr_last", log_addr[$], 'h32);
      chk("ign_count", word_count, 3);

      // Random sessions
      rand_stall = 1'b1;
      for (int s = 0; s < 25; s++) begin
         int nb;
         nb = 1 + int'($urandom % 8);
         pulse_start(int'($urandom % 256));
         for (int b = 0; b < nb; b++) begin
            if ($urandom % 6 == 0) pulse_start(int'($urandom % 256));
            if ($urandom % 3 == 0) cycles(1 + int'($urandom % 3));
            send_rand(b == nb - 1, 40, ok, w);
            if (!ok) break;
         end
         wait_end("rand");
      end
      rand_stall = 1'b0;
      cycles(2);
      mem_stall = 1'b0;
      cycles(2);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

endmodule

// File: doc/instr_assemble.md
INSTR_ASSEMBLE -- requirements
Module: instr_assemble

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the encoded-word FIFO depth (power of two, at least 2).
REQ-002 Parameter AW, default 8, SHALL set the instruction-memory address width.
REQ-003 The block SHALL have one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 start  input  1  one-cycle pulse; begins a load session at base_addr.
REQ-007 base_addr  input  AW  first instruction-memory address written after start.
REQ-008 in_valid  input  1  field set presented.
REQ-009 in_ready  output  1  field set accepted when in_valid and in_ready are both 1.
REQ-010 in_fmt  input  1  0 = R-format, 1 = D-format.
REQ-011 in_opcode  input  11  instruction opcode.
REQ-012 in_rm  input  5  R-format second source register.
REQ-013 in_rn  input  5  first source / base register.
REQ-014 in_rd  input  5  destination (R-format) or transfer register (D-format).
REQ-015 in_address  input  9  D-format offset.
REQ-016 in_last  input  1  marks the final field set of the session.
REQ-017 mem_stall  input  1  instruction memory cannot take a write this cycle.
REQ-018 imem_we  output  1  write strobe.
REQ-019 imem_addr  output  AW  write address.
REQ-020 imem_wdata  output  `INSTR_LEN  encoded instruction word.
REQ-021 busy, done, overflow  output  1 each  session-status flags.
REQ-022 word_count  output  AW+1  words written in the current session.

Function
REQ-023 Encoding SHALL be: bits [31:21] = in_opcode, bits [9:5] = in_rn, bits [4:0] = in_rd.
REQ-024 For R-format, bits [20:16] SHALL be in_rm and bits [15:10] SHALL be 0.
REQ-025 For D-format, bits [20:12] SHALL be in_address and bits [11:10] SHALL be 0.
REQ-026 The FSM SHALL have states IDLE, RUN, FLUSH, DONE and ERR.
REQ-027 FSM transitions SHALL be:
  - IDLE/DONE/ERR + start -> RUN: FIFO cleared, write pointer = base_addr, word_count = 0, done = 0, overflow = 0.
  - RUN + accepted beat with in_last = 1 -> FLUSH.
  - FLUSH + FIFO empty -> DONE.
REQ-028 A start pulse received in RUN or FLUSH SHALL be ignored.
REQ-029 in_ready SHALL be 1 only in RUN with the FIFO not full; there is no push/pop pass-through while full.
REQ-030 An encoded word SHALL enter the FIFO on the edge that accepts its beat.
REQ-031 Drain: in RUN or FLUSH, with the FIFO non-empty and mem_stall = 0, imem_we SHALL be 1, imem_addr SHALL be the write pointer and imem_wdata SHALL be the FIFO head.
REQ-032 On each drain edge the FIFO SHALL pop, the write pointer SHALL increment and word_count SHALL increment.
REQ-033 imem_we SHALL be driven combinationally; a beat accepted at edge N into an empty FIFO SHALL be written in cycle N+1 if not stalled, giving one cycle of latency.
REQ-034 FIFO ordering SHALL be strict FIFO; simultaneous push and pop SHALL keep the occupancy unchanged.
REQ-035 If a write occurs with the write pointer at 2^AW-1, the pointer SHALL NOT wrap; overflow SHALL be set, the state SHALL go to ERR, the FIFO SHALL be discarded and in_ready SHALL be 0 until the next start.
REQ-036 busy SHALL be 1 in RUN and FLUSH; done SHALL be 1 in DONE only.
REQ-037 In IDLE, DONE and ERR, imem_we SHALL be 0 regardless of FIFO state.

Reset
REQ-038 While rst = 1, the block SHALL enter IDLE and clear the FIFO.
REQ-039 While rst = 1, in_ready, imem_we, busy, done and overflow SHALL be 0.
REQ-040 While rst = 1, imem_addr, imem_wdata and word_count SHALL be 0.
REQ-041 Reset SHALL override start and any in-flight beat in the same cycle.
REQ-042 Reset mid-session SHALL discard all buffered words with no further writes.

Verification
REQ-043 Basic R-format: start, base_addr = 0x10, one R beat (opcode 0x458, rm 2, rn 1, rd 3, last) -> next cycle imem_we = 1, addr 0x10, wdata 0x8B020023; then done = 1, word_count = 1.
REQ-044 Basic D-format: D beat (opcode 0x7C2, address 8, rn 2, rd 5) -> wdata 0xF8408045 with bits [11:10] = 0.
REQ-045 Backpressure: mem_stall held at 1 while 6 beats are offered -> in_ready drops after 4 acceptances; on stall release, addresses base..base+5 are written in order with no loss or duplication.
REQ-046 Overflow: base_addr = 0xFE with 3 beats -> writes at 0xFE and 0xFF, then overflow = 1, state ERR, third word never written, in_ready = 0.
REQ-047 Reset and restart: rst asserted with 2 words buffered -> no imem_we afterwards; a new start with base_addr = 0 resumes cleanly at address 0 with word_count restarting from 0.
REQ-048 Ignored start: start pulsed during RUN -> pointer, count and FIFO contents unchanged.
